// File: rtl/sha256_nonce_sequencer.sv
// Drives one sha256_transform: sequences cnt/feedback, sweeps a nonce range through rx_input,
// and pairs each returned hash with the nonce that produced it to flag golden nonces.
`timescale 1ns/1ps
module sha256_nonce_sequencer #(
    parameter int unsigned LOOP             = 4,
    parameter int unsigned TARGET_ZERO_BITS = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic [255:0] midstate_in,
    input  logic [511:0] data_in,
    input  logic [31:0]  nonce_start,
    input  logic [31:0]  nonce_last,
    output logic [5:0]   cnt,
    output logic         feedback,
    output logic [255:0] tx_state,
    output logic [511:0] tx_input,
    input  logic [255:0] hash_in,
    output logic         busy,
    output logic         golden_valid,
    output logic [31:0]  golden_nonce,
    output logic         done
);

    localparam int unsigned STAGES   = 64 / LOOP;
    localparam logic [5:0]  CNT_MAX  = 6'(LOOP - 1);
    localparam logic [6:0]  STAGES_L = 7'(STAGES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [255:0]  midstate_q, midstate_d;
    logic [511:0]  data_q, data_d;
    logic [31:0]   nonce_q, nonce_d;
    logic [31:0]   last_q, last_d;
    logic [31:0]   check_nonce_q, check_nonce_d;
    logic [6:0]    loads_q, loads_d;
    logic          check_pend_q, check_pend_d;
    logic          golden_valid_q, golden_valid_d;
    logic [31:0]   golden_nonce_q, golden_nonce_d;
    logic          done_q, done_d;

    logic          active;
    logic          load_edge;
    logic          hash_match;
    logic          unused_bits;

    assign active     = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign load_edge  = active && (cnt_q == 6'd0);
    assign hash_match = (hash_in[255 -: TARGET_ZERO_BITS] == '0);

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        midstate_d     = midstate_q;
        data_d         = data_q;
        nonce_d        = nonce_q;
        last_d         = last_q;
        check_nonce_d  = check_nonce_q;
        loads_d        = loads_q;
        check_pend_d   = 1'b0;
        done_d         = 1'b0;
        golden_valid_d = 1'b0;
        golden_nonce_d = golden_nonce_q;

        case (state_q)
            S_IDLE: begin
                cnt_d = 6'd0;
                if (start && !stop) begin
                    midstate_d    = midstate_in;
                    data_d        = data_in;
                    nonce_d       = nonce_start;
                    last_d        = nonce_last;
                    check_nonce_d = nonce_start;
                    loads_d       = 7'd0;
                    state_d       = S_RUN;
                end
            end
            S_RUN, S_DRAIN: begin
                cnt_d = (cnt_q == CNT_MAX) ? 6'd0 : cnt_q + 6'd1;
                if (load_edge) begin
                    nonce_d      = nonce_q + 32'd1;
                    loads_d      = (loads_q == STAGES_L) ? loads_q : loads_q + 7'd1;
                    // The hash arriving after this load belongs to a real load only once
                    // the pipeline has been filled by STAGES earlier loads.
                    check_pend_d = (loads_q == STAGES_L);
                    if ((state_q == S_RUN) && (nonce_q == last_q)) begin
                        state_d = S_DRAIN;
                    end
                end
                if (check_pend_q) begin
                    check_nonce_d = check_nonce_q + 32'd1;
                    if (check_nonce_q == last_q) begin
                        state_d      = S_DONE;
                        cnt_d        = 6'd0;
                        check_pend_d = 1'b0;
                    end
                end
            end
            S_DONE: begin
                cnt_d   = 6'd0;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 6'd0;
            end
        endcase

        // A check already in flight this cycle still reports, even when stop aborts the job.
        if (check_pend_q && hash_match) begin
            golden_valid_d = 1'b1;
            golden_nonce_d = check_nonce_q;
        end

        if (stop && (state_q != S_IDLE)) begin
            state_d      = S_IDLE;
            cnt_d        = 6'd0;
            done_d       = 1'b0;
            check_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= 6'd0;
            nonce_q        <= 32'd0;
            last_q         <= 32'd0;
            check_nonce_q  <= 32'd0;
            loads_q        <= 7'd0;
            check_pend_q   <= 1'b0;
            golden_valid_q <= 1'b0;
            golden_nonce_q <= 32'd0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            nonce_q        <= nonce_d;
            last_q         <= last_d;
            check_nonce_q  <= check_nonce_d;
            loads_q        <= loads_d;
            check_pend_q   <= check_pend_d;
            golden_valid_q <= golden_valid_d;
            golden_nonce_q <= golden_nonce_d;
            done_q         <= done_d;
        end
    end

    // Job payload registers carry no reset; they are only meaningful after a start.
    always_ff @(posedge clk) begin
        midstate_q <= midstate_d;
        data_q     <= data_d;
    end

    for (genvar gi = 0; gi < 16; gi++) begin : g_word
        if (gi == 3) begin : g_nonce
            assign tx_input[gi*32 +: 32] = nonce_q;
        end else begin : g_data
            assign tx_input[gi*32 +: 32] = data_q[gi*32 +: 32];
        end
    end

    assign unused_bits  = ^{data_q[127:96], hash_in};

    assign cnt          = cnt_q;
    assign feedback     = (cnt_q != 6'd0);
    assign tx_state     = midstate_q;
    assign busy         = active;
    assign golden_valid = golden_valid_q;
    assign golden_nonce = golden_nonce_q;
    assign done         = done_q;

endmodule

// File: tb/tb_sha256_nonce_sequencer.sv
// Bench for sha256_nonce_sequencer: a LOOP=4 instance fed by a pipelined transform stub and a
// LOOP=1 instance fed by a constant hash; golden nonces are scoreboarded per job.
`timescale 1ns/1ps
module tb_sha256_nonce_sequencer;

    localparam int unsigned LOOP1   = 4;
    localparam int unsigned STAGES1 = 64 / LOOP1;
    localparam int unsigned LOOP2   = 1;
    localparam int unsigned STAGES2 = 64 / LOOP2;

    logic clk;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    // instance 1 (LOOP=4, 32 target bits)
    logic         start1, stop1;
    logic [255:0] mid1;
    logic [511:0] data1;
    logic [31:0]  ns1, nl1;
    logic [5:0]   cnt1;
    logic         fb1, busy1, gv1, done1;
    logic [255:0] txs1, hash1;
    logic [511:0] txi1;
    logic [31:0]  gn1;
    // instance 2 (LOOP=1, 8 target bits)
    logic         start2, stop2;
    logic [255:0] mid2;
    logic [511:0] data2;
    logic [31:0]  ns2, nl2;
    logic [5:0]   cnt2;
    logic         fb2, busy2, gv2, done2;
    logic [255:0] txs2, hash2;
    logic [511:0] txi2;
    logic [31:0]  gn2;

    sha256_nonce_sequencer #(.LOOP(LOOP1), .TARGET_ZERO_BITS(32)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .stop(stop1),
        .midstate_in(mid1), .data_in(data1), .nonce_start(ns1), .nonce_last(nl1),
        .cnt(cnt1), .feedback(fb1), .tx_state(txs1), .tx_input(txi1), .hash_in(hash1),
        .busy(busy1), .golden_valid(gv1), .golden_nonce(gn1), .done(done1)
    );

    sha256_nonce_sequencer #(.LOOP(LOOP2), .TARGET_ZERO_BITS(8)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .stop(stop2),
        .midstate_in(mid2), .data_in(data2), .nonce_start(ns2), .nonce_last(nl2),
        .cnt(cnt2), .feedback(fb2), .tx_state(txs2), .tx_input(txi2), .hash_in(hash2),
        .busy(busy2), .golden_valid(gv2), .golden_nonce(gn2), .done(done2)
    );

    int          checks = 0;
    int          errors = 0;
    longint      cyc = 0;
    int          hash_mode = 0;
    logic [31:0] pipe1 [STAGES1];
    logic [31:0] sb1 [$];
    logic [31:0] sb2 [$];
    int          done_cnt1 = 0, done_cnt2 = 0;
    longint      last_gold_cyc1 = 0, last_gold_cyc2 = 0;
    logic [31:0] exp_load1, exp_load2;
    int          loads_left1 = 0, loads_left2 = 0;
    bit          expect_last_gold1 = 0, expect_last_gold2 = 0;
    logic [255:0] job_mid1, job_mid2;
    logic [511:0] job_data1, job_data2;
    logic        prev_busy1 = 0;
    logic [5:0]  prev_cnt1 = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Word 7 of the stubbed hash for a given nonce; zero means golden at 32 target bits.
    function automatic logic [31:0] stub_word7(input logic [31:0] n, input int mode);
        case (mode)
            0:       return 32'h0;
            1:       return (n == 32'hFFFF_FFFF) ? 32'h0 : 32'h1;
            default: return n[0] ? 32'h0 : (32'h100 | n);
        endcase
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Transform stub: STAGES-deep pipeline advancing on every cnt==0 edge.
    always @(posedge clk) begin
        if (cnt1 == 6'd0) begin
            pipe1[0] <= txi1[127:96];
            for (int i = 1; i < int'(STAGES1); i++) pipe1[i] <= pipe1[i-1];
            hash1 <= {stub_word7(pipe1[STAGES1-1], hash_mode), 224'h5a5a_a5a5_0f0f_f0f0_1234_5678_9abc_def0_0102_0304_0506_0708_090a_0b0c};
        end
    end

    // Instance 1 monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (gv1) begin
                if (sb1.size() == 0) begin
                    check_eq("gold1_unexpected", 64'(gv1), 64'h0);
                end else begin
                    check_eq("gold1_nonce", 64'(gn1), 64'(sb1.pop_front()));
                end
                $display("inst1 golden nonce=%08h", gn1);
                last_gold_cyc1 <= cyc;
            end
            if (done1) begin
                done_cnt1 <= done_cnt1 + 1;
                if (expect_last_gold1) check_eq("gold1_done_gap", 64'(cyc - last_gold_cyc1), 64'd1);
            end
            if (busy1 && cnt1 == 6'd0 && loads_left1 > 0) begin
                check_eq("load1_nonce", 64'(txi1[127:96]), 64'(exp_load1));
                check_eq("load1_static", {62'd0, txs1 == job_mid1,
                         {txi1[511:128], txi1[95:0]} == {job_data1[511:128], job_data1[95:0]}}, 64'd3);
                exp_load1   <= exp_load1 + 32'd1;
                loads_left1 <= loads_left1 - 1;
            end
            if (busy1 && prev_busy1) begin
                check_eq("cnt1_step", 64'(cnt1), 64'((int'(prev_cnt1) + 1) % int'(LOOP1)));
                check_eq("fb1", 64'(fb1), 64'(cnt1 != 6'd0));
            end
        end
        prev_busy1 <= busy1 && !reset;
        prev_cnt1  <= cnt1;
    end

    // Instance 2 monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (gv2) begin
                if (sb2.size() == 0) begin
                    check_eq("gold2_unexpected", 64'(gv2), 64'h0);
                end else begin
                    check_eq("gold2_nonce", 64'(gn2), 64'(sb2.pop_front()));
                end
                $display("inst2 golden nonce=%08h", gn2);
                last_gold_cyc2 <= cyc;
            end
            if (done2) begin
                done_cnt2 <= done_cnt2 + 1;
                if (expect_last_gold2) check_eq("gold2_done_gap", 64'(cyc - last_gold_cyc2), 64'd1);
            end
            if (busy2) begin
                check_eq("cnt2_fb_zero", {57'd0, cnt2, fb2}, 64'd0);
                if (loads_left2 > 0) begin
                    check_eq("load2_nonce", 64'(txi2[127:96]), 64'(exp_load2));
                    exp_load2   <= exp_load2 + 32'd1;
                    loads_left2 <= loads_left2 - 1;
                end
            end
        end
    end

    task automatic rand_payload(output logic [255:0] m, output logic [511:0] d);
        for (int i = 0; i < 8; i++) m[i*32 +: 32] = $urandom;
        for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom;
    endtask

    task automatic run_job1(input logic [31:0] first, input logic [31:0] last, input int mode,
                            input bit last_gold, input int poke_at);
        logic [31:0] v;
        int n, cycles, dc;
        v = last - first;
        n = int'(v) + 1;
        hash_mode = mode;
        v = first;
        forever begin
            if (stub_word7(v, mode) == 32'h0) sb1.push_back(v);
            if (v == last) break;
            v = v + 32'd1;
        end
        rand_payload(job_mid1, job_data1);
        mid1 = job_mid1; data1 = job_data1; ns1 = first; nl1 = last;
        exp_load1 = first; loads_left1 = n; expect_last_gold1 = last_gold; dc = done_cnt1;
        start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        cycles = 0;
        while (done1 !== 1'b1 && cycles < 3000) begin
            @(posedge clk); cycles++; #1;
            start1 = (cycles == poke_at);
            if (start1) begin
                ns1 = 32'h500; nl1 = 32'h501; mid1 = ~job_mid1; data1 = ~job_data1;
            end
        end
        start1 = 1'b0;
        check_eq("done1_seen", 64'(done1), 64'd1);
        check_eq("done1_latency", 64'(cycles), 64'(int'(LOOP1) * (n + int'(STAGES1)) - int'(LOOP1) + 3));
        @(negedge clk); #1;
        check_eq("sb1_empty", 64'(sb1.size()), 64'd0);
        check_eq("done1_count", 64'(done_cnt1 - dc), 64'd1);
        check_eq("busy1_after_done", 64'(busy1), 64'd0);
        $display("inst1 job %08h..%08h mode %0d finished in %0d cycles", first, last, mode, cycles);
        expect_last_gold1 = 0;
    endtask

    task automatic run_job2(input logic [31:0] first, input logic [31:0] last, input logic [31:0] w7,
                            input bit last_gold);
        logic [31:0] v;
        int n, cycles, dc;
        v = last - first;
        n = int'(v) + 1;
        hash2 = {w7, 224'hcb00_41ff_5b3a_1c9d_0e2f_3401_6789_aaaa_bbbb_cccc_dddd_eeee_ffff_1111};
        v = first;
        forever begin
            if (w7[31:24] == 8'h0) sb2.push_back(v);
            if (v == last) break;
            v = v + 32'd1;
        end
        rand_payload(job_mid2, job_data2);
        mid2 = job_mid2; data2 = job_data2; ns2 = first; nl2 = last;
        exp_load2 = first; loads_left2 = n; expect_last_gold2 = last_gold; dc = done_cnt2;
        start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        cycles = 0;
        while (done2 !== 1'b1 && cycles < 3000) begin
            @(posedge clk); cycles++; #1;
        end
        check_eq("done2_seen", 64'(done2), 64'd1);
        check_eq("done2_latency", 64'(cycles), 64'(int'(LOOP2) * (n + int'(STAGES2)) - int'(LOOP2) + 3));
        @(negedge clk); #1;
        check_eq("sb2_empty", 64'(sb2.size()), 64'd0);
        check_eq("done2_count", 64'(done_cnt2 - dc), 64'd1);
        check_eq("tx_state2", 64'(txs2 == job_mid2), 64'd1);
        $display("inst2 job %08h..%08h word7 %08h finished in %0d cycles", first, last, w7, cycles);
        expect_last_gold2 = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_busy"},  64'(busy1), 64'd0);
        check_eq({tag, "_cnt"},   64'({cnt1, fb1}), 64'd0);
        check_eq({tag, "_gv"},    64'(gv1), 64'd0);
        check_eq({tag, "_gn"},    64'(gn1), 64'd0);
        check_eq({tag, "_done"},  64'(done1), 64'd0);
    endtask

    initial begin
        int dc;
        reset = 1'b1;
        start1 = 0; stop1 = 0; mid1 = '0; data1 = '0; ns1 = 0; nl1 = 0;
        start2 = 0; stop2 = 0; mid2 = '0; data2 = '0; ns2 = 0; nl2 = 0;
        hash2 = '1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("por1");
        check_eq("por2", {56'd0, busy2, gv2, done2, fb2, 4'd0}, 64'd0);
        check_eq("por2_gn_cnt", {26'd0, gn2, cnt2}, 64'd0);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // every hash golden; a start pulse mid-run must be ignored
        run_job1(32'h10, 32'h12, 0, 1, 10);
        // single golden across the 32-bit wrap
        run_job1(32'hFFFF_FFFE, 32'h0000_0001, 1, 0, -1);

        // stop five cycles into RUN
        rand_payload(job_mid1, job_data1);
        mid1 = job_mid1; data1 = job_data1; ns1 = 32'h0; nl1 = 32'h2;
        hash_mode = 0; exp_load1 = 32'h0; loads_left1 = 3; dc = done_cnt1;
        start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        repeat (4) @(posedge clk);
        #1 stop1 = 1'b1;
        @(posedge clk); #1 stop1 = 1'b0;
        loads_left1 = 0;
        check_eq("stop_busy", 64'(busy1), 64'd0);
        check_eq("stop_cnt", 64'(cnt1), 64'd0);
        repeat (120) @(posedge clk);
        #1;
        check_eq("stop_no_done", 64'(done_cnt1 - dc), 64'd0);
        check_eq("stop_idle", 64'(busy1), 64'd0);
        $display("inst1 stop test complete");
        run_job1(32'h0, 32'h2, 2, 0, -1);

        // reset while draining
        rand_payload(job_mid1, job_data1);
        mid1 = job_mid1; data1 = job_data1; ns1 = 32'h20; nl1 = 32'h21;
        hash_mode = 0; exp_load1 = 32'h20; loads_left1 = 2; dc = done_cnt1;
        start1 = 1'b1;
        @(posedge clk); #1 start1 = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check_eq("drain_busy", 64'(busy1), 64'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("midreset");
        reset = 1'b0;
        loads_left1 = 0;
        repeat (120) @(posedge clk);
        #1;
        check_eq("midreset_no_done", 64'(done_cnt1 - dc), 64'd0);
        check_eq("midreset_idle", 64'(busy1), 64'd0);
        $display("inst1 reset-in-drain test complete");

        // LOOP=1 instance: leading byte nonzero -> no golden; then 8 leading zeros -> all golden
        run_job2(32'h8000_0000, 32'h8000_0000, 32'hba78_16bf, 0);
        run_job2(32'h0, 32'h9, 32'h00ff_ffff, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
